// File: rtl/digit_entry_buffer.sv
// Keypad entry stage: keeps a right-aligned BCD digit stack and converts it to
// binary with one multiply-by-ten-and-add step per digit slot, MS slot first.
module digit_entry_buffer #(
  parameter int MAX_DIGITS = 5,
  parameter int WIDTH      = 17
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  output logic [WIDTH-1:0]        data_buffer,
  output logic [4*MAX_DIGITS-1:0] digits,
  output logic [2:0]              digit_count,
  output logic                    busy,
  output logic                    value_valid,
  output logic                    entry_done,
  output logic                    key_ignored
);
  localparam int       DW     = 4 * MAX_DIGITS;
  localparam bit [2:0] C_MAX  = 3'(MAX_DIGITS);
  localparam bit [2:0] C_LAST = 3'(MAX_DIGITS - 1);

  typedef enum logic {S_IDLE, S_CONVERT} state_t;

  state_t           r_state;
  logic [DW-1:0]    r_digits;
  logic [2:0]       r_count;
  logic [2:0]       r_step;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_data;
  logic             r_busy;
  logic             r_valid;
  logic             r_done;
  logic             r_ign;
  logic             r_fresh;

  logic             w_key_idle;
  logic             w_digit_acc;
  logic             w_bs_key;
  logic             w_bs_acc;
  logic             w_clear;
  logic             w_enter_acc;
  logic             w_reject;
  logic             w_start;
  logic [DW-1:0]    w_key_ext;
  logic [3:0]       w_slot;
  logic [WIDTH-1:0] w_acc_next;

  assign w_key_idle  = key_valid && (r_state == S_IDLE);
  assign w_digit_acc = w_key_idle && (key_code <= 4'd9) && (r_fresh || (r_count != C_MAX));
  assign w_bs_key    = w_key_idle && (key_code == 4'hA);
  assign w_bs_acc    = w_bs_key && (r_count != 3'd0);
  assign w_clear     = w_key_idle && (key_code == 4'hB);
  assign w_enter_acc = w_key_idle && (key_code == 4'hC) && (r_count != 3'd0) && r_valid;
  // Anything not accepted in IDLE, and every key seen during CONVERT, is a rejection.
  assign w_reject    = key_valid && !(w_digit_acc || w_bs_acc || w_clear || w_enter_acc);
  assign w_start     = w_digit_acc || w_bs_acc;
  assign w_key_ext   = DW'(key_code);

  always_comb begin
    w_slot = 4'd0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (r_step == 3'(MAX_DIGITS - 1 - i)) w_slot = r_digits[4*i +: 4];
    end
  end

  assign w_acc_next = (r_acc << 3) + (r_acc << 1) + WIDTH'(w_slot);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_digits <= '0;
      r_count  <= 3'd0;
      r_step   <= 3'd0;
      r_acc    <= '0;
      r_data   <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b1;
      r_done   <= 1'b0;
      r_ign    <= 1'b0;
      r_fresh  <= 1'b0;
    end else begin
      r_done <= w_enter_acc;
      r_ign  <= w_reject;
      if (w_enter_acc) r_fresh <= 1'b1;
      if (w_digit_acc || w_bs_key || w_clear) r_fresh <= 1'b0;

      if (w_digit_acc) begin
        r_digits <= r_fresh ? w_key_ext : ((r_digits << 4) | w_key_ext);
        r_count  <= r_fresh ? 3'd1 : (r_count + 3'd1);
      end else if (w_bs_acc) begin
        r_digits <= r_digits >> 4;
        r_count  <= r_count - 3'd1;
      end else if (w_clear) begin
        r_digits <= '0;
        r_count  <= 3'd0;
        r_data   <= '0;
        r_valid  <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_CONVERT;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
            r_acc   <= '0;
            r_step  <= 3'd0;
          end
        end
        S_CONVERT: begin
          if (r_step == C_LAST) begin
            r_data  <= w_acc_next;
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_acc  <= w_acc_next;
            r_step <= r_step + 3'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_buffer = r_data;
  assign digits      = r_digits;
  assign digit_count = r_count;
  assign busy        = r_busy;
  assign value_valid = r_valid;
  assign entry_done  = r_done;
  assign key_ignored = r_ign;
endmodule

// File: tb/tb_digit_entry_buffer.sv
// Scenario bench for digit_entry_buffer: a decimal model pushes expected
// data_buffer values on accepted keys; they are popped when busy falls.
module tb_digit_entry_buffer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic [16:0] data_buffer;
  logic [19:0] digits;
  logic [2:0]  digit_count;
  logic        busy, value_valid, entry_done, key_ignored;

  int errors = 0;
  int checks = 0;
  int m_val = 0;
  int m_cnt = 0;
  bit m_fresh = 1'b0;
  int sb[$];
  int exp_v;
  int n;

  digit_entry_buffer #(.MAX_DIGITS(5), .WIDTH(17)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .data_buffer(data_buffer), .digits(digits), .digit_count(digit_count),
    .busy(busy), .value_valid(value_valid), .entry_done(entry_done),
    .key_ignored(key_ignored)
  );

  always #5 clk = ~clk;

  // Decimal model of an accepted key press in IDLE; pushes expected result.
  task automatic model_key(input logic [3:0] c);
    if (c <= 4'd9) begin
      if (m_fresh) begin m_val = 0; m_cnt = 0; m_fresh = 1'b0; end
      if (m_cnt < 5) begin
        m_val = m_val * 10 + int'(c); m_cnt++; sb.push_back(m_val);
      end
    end else if (c == 4'hA) begin
      m_fresh = 1'b0;
      if (m_cnt > 0) begin m_val = m_val / 10; m_cnt--; sb.push_back(m_val); end
    end else if (c == 4'hB) begin
      m_val = 0; m_cnt = 0; m_fresh = 1'b0;
    end else if (c == 4'hC && m_cnt > 0) begin
      m_fresh = 1'b1;
    end
  endtask

  // One-cycle key strobe; returns at the negedge right after the sampling edge.
  task automatic press(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1; key_code = c;
    @(negedge clk);
    key_valid = 1'b0;
    $display("key %h -> busy=%0b ign=%0b done=%0b count=%0d", c, busy, key_ignored, entry_done, digit_count);
  endtask

  // Counts busy cycles (bounded) starting at the current negedge.
  task automatic run_conv(output int cyc);
    cyc = 0;
    while (busy && cyc < 20) begin cyc++; @(negedge clk); end
  endtask

  task automatic pop_exp(output int v);
    if (sb.size() == 0) begin
      v = -1;
      $display("FAIL scoreboard_empty: no expected value queued");
    end else v = sb.pop_front();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({data_buffer, digits, digit_count, busy, value_valid, entry_done, key_ignored} !== {17'd0, 20'd0, 3'd0, 4'b0100}) begin
      errors++;
      $display("FAIL reset_state: got data=%0d digits=%h cnt=%0d b=%0b v=%0b d=%0b i=%0b want 0/0/0/0/1/0/0",
               data_buffer, digits, digit_count, busy, value_valid, entry_done, key_ignored);
    end
  endtask

  task automatic test_digits;
    for (int d = 1; d <= 5; d++) begin
      model_key(4'(d)); press(4'(d));
      run_conv(n);
      pop_exp(exp_v);
      checks++;
      if (n !== 5) begin errors++; $display("FAIL busy_len: got %0d want 5", n); end
      checks++;
      if (int'(data_buffer) !== exp_v || value_valid !== 1'b1) begin
        errors++; $display("FAIL digit_value: got %0d v=%0b want %0d v=1", data_buffer, value_valid, exp_v);
      end
      repeat (6) @(negedge clk);
    end
    checks++;
    if (digits !== 20'h12345 || digit_count !== 3'd5) begin
      errors++; $display("FAIL stack_12345: got %h cnt=%0d want 12345 cnt=5", digits, digit_count);
    end
  endtask

  task automatic test_overflow;
    model_key(4'hB); press(4'hB);
    for (int i = 0; i < 5; i++) begin
      model_key(4'd9); press(4'd9); run_conv(n); pop_exp(exp_v);
    end
    checks++;
    if (int'(data_buffer) !== exp_v) begin errors++; $display("FAIL value_99999: got %0d want %0d", data_buffer, exp_v); end
    press(4'd7);
    checks++;
    if (key_ignored !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL overflow_ignored: got ign=%0b busy=%0b want 1/0", key_ignored, busy);
    end
    @(negedge clk);
    checks++;
    if (key_ignored !== 1'b0 || data_buffer !== 17'd99999 || digit_count !== 3'd5) begin
      errors++; $display("FAIL overflow_hold: got ign=%0b data=%0d cnt=%0d want 0/99999/5", key_ignored, data_buffer, digit_count);
    end
    model_key(4'hA); press(4'hA); run_conv(n); pop_exp(exp_v);
    checks++;
    if (int'(data_buffer) !== exp_v || n !== 5) begin
      errors++; $display("FAIL backspace_value: got %0d in %0d cyc want %0d in 5", data_buffer, n, exp_v);
    end
  endtask

  task automatic test_back_to_back;
    model_key(4'hB); press(4'hB);
    model_key(4'd4);
    @(negedge clk); key_valid = 1'b1; key_code = 4'd4;
    @(negedge clk); key_code = 4'd2;
    @(negedge clk); key_valid = 1'b0;
    $display("key 4,2 back-to-back -> busy=%0b ign=%0b", busy, key_ignored);
    checks++;
    if (key_ignored !== 1'b1) begin errors++; $display("FAIL busy_drop: got ign=%0b want 1", key_ignored); end
    run_conv(n); pop_exp(exp_v);
    checks++;
    if (int'(data_buffer) !== exp_v || digit_count !== 3'd1) begin
      errors++; $display("FAIL busy_final: got %0d cnt=%0d want %0d cnt=1", data_buffer, digit_count, exp_v);
    end
  endtask

  task automatic test_enter;
    logic [3:0] seq [4] = '{4'd4, 4'd2, 4'd0, 4'd7};
    model_key(4'hB); press(4'hB);
    foreach (seq[i]) begin model_key(seq[i]); press(seq[i]); run_conv(n); pop_exp(exp_v); end
    checks++;
    if (digits !== 20'h04207 || digit_count !== 3'd4) begin
      errors++; $display("FAIL stack_4207: got %h cnt=%0d want 04207 cnt=4", digits, digit_count);
    end
    model_key(4'hC); press(4'hC);
    checks++;
    if (entry_done !== 1'b1 || key_ignored !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL enter_pulse: got done=%0b ign=%0b busy=%0b want 1/0/0", entry_done, key_ignored, busy);
    end
    @(negedge clk);
    checks++;
    if (entry_done !== 1'b0 || int'(data_buffer) !== exp_v) begin
      errors++; $display("FAIL enter_after: got done=%0b data=%0d want 0/%0d", entry_done, data_buffer, exp_v);
    end
    model_key(4'd3); press(4'd3); run_conv(n); pop_exp(exp_v);
    checks++;
    if (int'(data_buffer) !== exp_v || digit_count !== 3'd1 || digits !== 20'h00003) begin
      errors++; $display("FAIL fresh_digit: got %0d cnt=%0d digits=%h want %0d cnt=1 digits=00003", data_buffer, digit_count, digits, exp_v);
    end
  endtask

  task automatic test_empty_and_clear;
    model_key(4'hB); press(4'hB);
    press(4'hC);
    checks++;
    if (key_ignored !== 1'b1 || entry_done !== 1'b0) begin
      errors++; $display("FAIL empty_enter: got ign=%0b done=%0b want 1/0", key_ignored, entry_done);
    end
    press(4'hA);
    checks++;
    if (key_ignored !== 1'b1 || busy !== 1'b0 || data_buffer !== 17'd0 || digit_count !== 3'd0) begin
      errors++; $display("FAIL empty_backspace: got ign=%0b busy=%0b data=%0d cnt=%0d want 1/0/0/0", key_ignored, busy, data_buffer, digit_count);
    end
    press(4'hE);
    checks++;
    if (key_ignored !== 1'b1) begin errors++; $display("FAIL code_e: got ign=%0b want 1", key_ignored); end
    for (int d = 8; d != 3; d = (d == 8) ? 1 : d + 1) begin
      model_key(4'(d)); press(4'(d)); run_conv(n); pop_exp(exp_v);
    end
    checks++;
    if (int'(data_buffer) !== exp_v) begin errors++; $display("FAIL value_812: got %0d want %0d", data_buffer, exp_v); end
    model_key(4'hB); press(4'hB);
    checks++;
    if (data_buffer !== 17'd0 || digit_count !== 3'd0 || digits !== 20'd0 || value_valid !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL clear: got data=%0d cnt=%0d digits=%h v=%0b busy=%0b want 0/0/0/1/0", data_buffer, digit_count, digits, value_valid, busy);
    end
  endtask

  task automatic test_reset_abort;
    model_key(4'd5); press(4'd5);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete(); m_val = 0; m_cnt = 0; m_fresh = 1'b0;
    checks++;
    if ({data_buffer, digits, digit_count, busy, value_valid, entry_done, key_ignored} !== {17'd0, 20'd0, 3'd0, 4'b0100}) begin
      errors++; $display("FAIL reset_abort: got data=%0d digits=%h cnt=%0d b=%0b v=%0b want 0/0/0/0/1",
                         data_buffer, digits, digit_count, busy, value_valid);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (data_buffer !== 17'd0 || value_valid !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_stale: got data=%0d v=%0b busy=%0b want 0/1/0", data_buffer, value_valid, busy);
    end
  endtask

  initial begin
    test_reset;
    test_digits;
    test_overflow;
    test_back_to_back;
    test_enter;
    test_empty_and_clear;
    test_reset_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
